// File: rtl/watch_reload.sv
// Time-of-day/calendar counter (sec..month) from a sampled 1200 Hz timebase, with per-field edit strobes; quarter-hour pulse when WATCH_RELOAD_MIN15_EN is defined.
// Latency: baud edge to prescaler 3 cycles, fields update 1 cycle after sec_tick; no backpressure (free-running).
module watch_reload #(
  parameter int TICKS_PER_SEC  = 1200,
  parameter int DAYS_PER_MONTH = 30
) (
  input  logic       MH50,
  input  logic       rst,
  input  logic       baud_clk,
  input  logic       edit,
  input  logic       Esec,
  input  logic       Emin,
  input  logic       Ehour,
  input  logic       Eday,
  input  logic       Emonths,
  output logic [5:0] Hsec,
  output logic [5:0] Hmin,
  output logic [4:0] Hhour,
  output logic [4:0] Hday,
  output logic [3:0] Hmon,
  output logic       min15
);

  localparam logic [10:0] PRESC_MAX = 11'(TICKS_PER_SEC - 1);
  localparam logic [4:0]  DAY_MAX   = 5'(DAYS_PER_MONTH - 1);

  logic [6:0]  async_in;
  logic [6:0]  sync_q1;
  logic [6:0]  sync_q2;
  logic [5:0]  prev_q;
  logic        edit_s;
  logic        baud_rise;
  logic [4:0]  step;
  logic        sec_tick;
  logic [10:0] presc;
  logic [10:0] presc_nxt;
  logic [5:0]  sec_nxt;
  logic [5:0]  min_nxt;
  logic [4:0]  hour_nxt;
  logic [4:0]  day_nxt;
  logic [3:0]  mon_nxt;
  logic        sec_last;
  logic        min_last;
  logic        hour_last;
  logic        day_last;
  logic        mon_last;

  assign async_in  = {baud_clk, edit, Emonths, Eday, Ehour, Emin, Esec};
  assign edit_s    = sync_q2[5];
  // edit is a level, so only the timebase and the strobes keep a previous-value flop
  assign baud_rise = sync_q2[6] & ~prev_q[5];
  assign step      = sync_q2[4:0] & ~prev_q[4:0] & {5{edit_s}};

  always_ff @(posedge MH50) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      prev_q  <= '0;
      presc   <= '0;
      Hsec    <= '0;
      Hmin    <= '0;
      Hhour   <= '0;
      Hday    <= '0;
      Hmon    <= '0;
    end else begin
      sync_q1 <= async_in;
      sync_q2 <= sync_q1;
      prev_q  <= {sync_q2[6], sync_q2[4:0]};
      presc   <= presc_nxt;
      Hsec    <= sec_nxt;
      Hmin    <= min_nxt;
      Hhour   <= hour_nxt;
      Hday    <= day_nxt;
      Hmon    <= mon_nxt;
    end
  end

  always_comb begin
    sec_last  = (Hsec == 6'd59);
    min_last  = (Hmin == 6'd59);
    hour_last = (Hhour == 5'd23);
    day_last  = (Hday == DAY_MAX);
    mon_last  = (Hmon == 4'd11);

    sec_tick  = baud_rise && !edit_s && (presc == PRESC_MAX);
    presc_nxt = presc;
    if (baud_rise && !edit_s) begin
      presc_nxt = (presc == PRESC_MAX) ? 11'd0 : presc + 11'd1;
    end

    sec_nxt  = Hsec;
    min_nxt  = Hmin;
    hour_nxt = Hhour;
    day_nxt  = Hday;
    mon_nxt  = Hmon;

    if (sec_tick) begin
      // full carry chain resolves in a single cycle
      sec_nxt = sec_last ? 6'd0 : Hsec + 6'd1;
      if (sec_last) begin
        min_nxt = min_last ? 6'd0 : Hmin + 6'd1;
        if (min_last) begin
          hour_nxt = hour_last ? 5'd0 : Hhour + 5'd1;
          if (hour_last) begin
            day_nxt = day_last ? 5'd0 : Hday + 5'd1;
            if (day_last) begin
              mon_nxt = mon_last ? 4'd0 : Hmon + 4'd1;
            end
          end
        end
      end
    end else begin
      // edit steps wrap within their own field and never carry
      if (step[0]) sec_nxt  = sec_last  ? 6'd0 : Hsec + 6'd1;
      if (step[1]) min_nxt  = min_last  ? 6'd0 : Hmin + 6'd1;
      if (step[2]) hour_nxt = hour_last ? 5'd0 : Hhour + 5'd1;
      if (step[3]) day_nxt  = day_last  ? 5'd0 : Hday + 5'd1;
      if (step[4]) mon_nxt  = mon_last  ? 4'd0 : Hmon + 4'd1;
    end
  end

`ifdef WATCH_RELOAD_MIN15_EN
  logic quarter;

  always_comb begin
    quarter = sec_tick && (sec_nxt == 6'd0) &&
              ((min_nxt == 6'd0) || (min_nxt == 6'd15) ||
               (min_nxt == 6'd30) || (min_nxt == 6'd45));
  end

  always_ff @(posedge MH50) begin
    if (rst) begin
      min15 <= 1'b0;
    end else begin
      min15 <= quarter;
    end
  end
`else
  assign min15 = 1'b0;
`endif

endmodule

// File: tb/tb_watch_reload.sv
// Directed bench for watch_reload: reset, edit stepping/wrap, prescaler hold, carries, rollover, quarter-hour pulse.
module tb_watch_reload;

  logic       MH50 = 1'b0;
  logic       rst = 1'b1;
  logic       baud_clk = 1'b0;
  logic       edit = 1'b0;
  logic [4:0] estb = 5'd0;
  logic [5:0] Hsec;
  logic [5:0] Hmin;
  logic [4:0] Hhour;
  logic [4:0] Hday;
  logic [3:0] Hmon;
  logic       min15;
  logic [25:0] now_t;

  int nvec = 0;
  int nerr = 0;
  int m15_cnt = 0;
  int m15_base = 0;

`ifdef WATCH_RELOAD_MIN15_EN
  localparam int Q_EXP = 1;
`else
  localparam int Q_EXP = 0;
`endif

  watch_reload dut (
    .MH50    (MH50),
    .rst     (rst),
    .baud_clk(baud_clk),
    .edit    (edit),
    .Esec    (estb[0]),
    .Emin    (estb[1]),
    .Ehour   (estb[2]),
    .Eday    (estb[3]),
    .Emonths (estb[4]),
    .Hsec    (Hsec),
    .Hmin    (Hmin),
    .Hhour   (Hhour),
    .Hday    (Hday),
    .Hmon    (Hmon),
    .min15   (min15)
  );

  always #10 MH50 = ~MH50;

  assign now_t = {Hmon, Hday, Hhour, Hmin, Hsec};

  always @(posedge MH50) begin
    if (min15 === 1'b1) m15_cnt <= m15_cnt + 1;
  end

  function automatic logic [25:0] tv(input int mo, input int d, input int h, input int m, input int s);
    return {mo[3:0], d[4:0], h[4:0], m[5:0], s[5:0]};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge MH50);
  endtask

  task automatic baud_edges(input int n);
    repeat (n) begin
      baud_clk = 1'b1;
      cyc(2);
      baud_clk = 1'b0;
      cyc(2);
    end
  endtask

  task automatic run_sec();
    baud_edges(1200);
    cyc(6);
  endtask

  // field index: 0 sec, 1 min, 2 hour, 3 day, 4 month
  task automatic pulse(input int f, input int n);
    repeat (n) begin
      estb[f] = 1'b1;
      cyc(3);
      estb[f] = 1'b0;
      cyc(3);
    end
  endtask

  task automatic set_edit(input logic v);
    edit = v;
    cyc(5);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    edit = 1'b0;
    estb = 5'd0;
    baud_clk = 1'b0;
    cyc(4);
    rst = 1'b0;
    cyc(2);
  endtask

  task automatic test_reset();
    logic [25:0] exp_t;
    rst = 1'b1;
    edit = 1'b1;
    pulse(0, 3);
    baud_edges(5);
    edit = 1'b0;
    cyc(20);
    nvec++;
    if (now_t !== 26'd0) begin
      nerr++;
      $display("FAIL reset_fields: got %h expected %h", now_t, 26'd0);
    end
    nvec++;
    if (min15 !== 1'b0) begin
      nerr++;
      $display("FAIL reset_min15: got %b expected 0", min15);
    end
    rst = 1'b0;
    cyc(2);
    baud_edges(1199);
    cyc(6);
    nvec++;
    if (now_t !== 26'd0) begin
      nerr++;
      $display("FAIL reset_1199_edges: got %h expected %h", now_t, 26'd0);
    end
    baud_edges(1);
    cyc(6);
    exp_t = tv(0, 0, 0, 0, 1);
    nvec++;
    if (now_t !== exp_t) begin
      nerr++;
      $display("FAIL reset_1200_edges: got %h expected %h", now_t, exp_t);
    end
  endtask

  task automatic test_edit_seconds();
    logic [25:0] exp_t;
    do_reset();
    set_edit(1'b1);
    pulse(0, 2);
    set_edit(1'b0);
    exp_t = tv(0, 0, 0, 0, 2);
    nvec++;
    if (now_t !== exp_t) begin
      nerr++;
      $display("FAIL edit_sec_two: got %h expected %h", now_t, exp_t);
    end
    run_sec();
    exp_t = tv(0, 0, 0, 0, 3);
    nvec++;
    if (now_t !== exp_t) begin
      nerr++;
      $display("FAIL edit_sec_then_count: got %h expected %h", now_t, exp_t);
    end
  endtask

  task automatic test_edit_fields();
    logic [25:0] exp_t;
    do_reset();
    m15_base = m15_cnt;
    set_edit(1'b1);
    pulse(1, 2);
    pulse(2, 2);
    pulse(3, 2);
    pulse(4, 2);
    exp_t = tv(2, 2, 2, 2, 0);
    nvec++;
    if (now_t !== exp_t) begin
      nerr++;
      $display("FAIL edit_each_field: got %h expected %h", now_t, exp_t);
    end
    pulse(0, 59);
    set_edit(1'b0);
    run_sec();
    exp_t = tv(2, 2, 2, 3, 0);
    nvec++;
    if (now_t !== exp_t) begin
      nerr++;
      $display("FAIL carry_sec_to_min: got %h expected %h", now_t, exp_t);
    end

    set_edit(1'b1);
    pulse(1, 56);
    pulse(0, 59);
    set_edit(1'b0);
    nvec++;
    if (m15_cnt - m15_base !== 0) begin
      nerr++;
      $display("FAIL edit_no_min15: got %0d pulses expected 0", m15_cnt - m15_base);
    end
    m15_base = m15_cnt;
    run_sec();
    exp_t = tv(2, 2, 3, 0, 0);
    nvec++;
    if (now_t !== exp_t) begin
      nerr++;
      $display("FAIL carry_min_to_hour: got %h expected %h", now_t, exp_t);
    end
    nvec++;
    if (m15_cnt - m15_base !== Q_EXP) begin
      nerr++;
      $display("FAIL hour_min15: got %0d pulses expected %0d", m15_cnt - m15_base, Q_EXP);
    end

    set_edit(1'b1);
    pulse(2, 20);
    pulse(1, 59);
    pulse(0, 59);
    set_edit(1'b0);
    run_sec();
    exp_t = tv(2, 3, 0, 0, 0);
    nvec++;
    if (now_t !== exp_t) begin
      nerr++;
      $display("FAIL carry_hour_to_day: got %h expected %h", now_t, exp_t);
    end

    set_edit(1'b1);
    pulse(3, 26);
    pulse(2, 23);
    pulse(1, 59);
    pulse(0, 59);
    set_edit(1'b0);
    run_sec();
    exp_t = tv(3, 0, 0, 0, 0);
    nvec++;
    if (now_t !== exp_t) begin
      nerr++;
      $display("FAIL carry_day_to_month: got %h expected %h", now_t, exp_t);
    end
  endtask

  task automatic test_edit_wrap_hold();
    logic [25:0] exp_t;
    do_reset();
    baud_edges(600);
    set_edit(1'b1);
    pulse(0, 61);
    baud_edges(700);
    set_edit(1'b0);
    exp_t = tv(0, 0, 0, 0, 1);
    nvec++;
    if (now_t !== exp_t) begin
      nerr++;
      $display("FAIL edit_sec_wrap: got %h expected %h", now_t, exp_t);
    end
    pulse(1, 1);
    nvec++;
    if (now_t !== exp_t) begin
      nerr++;
      $display("FAIL strobe_outside_edit: got %h expected %h", now_t, exp_t);
    end
    baud_edges(599);
    cyc(6);
    nvec++;
    if (now_t !== exp_t) begin
      nerr++;
      $display("FAIL presc_hold_early: got %h expected %h", now_t, exp_t);
    end
    baud_edges(1);
    cyc(6);
    exp_t = tv(0, 0, 0, 0, 2);
    nvec++;
    if (now_t !== exp_t) begin
      nerr++;
      $display("FAIL presc_hold_resume: got %h expected %h", now_t, exp_t);
    end
  endtask

  task automatic test_rollover();
    logic [25:0] exp_t;
    do_reset();
    set_edit(1'b1);
    pulse(1, 59);
    pulse(0, 59);
    pulse(2, 23);
    pulse(3, 29);
    pulse(4, 11);
    set_edit(1'b0);
    exp_t = tv(11, 29, 23, 59, 59);
    nvec++;
    if (now_t !== exp_t) begin
      nerr++;
      $display("FAIL rollover_preset: got %h expected %h", now_t, exp_t);
    end
    m15_base = m15_cnt;
    run_sec();
    nvec++;
    if (now_t !== 26'd0) begin
      nerr++;
      $display("FAIL rollover_all_zero: got %h expected %h", now_t, 26'd0);
    end
    nvec++;
    if (m15_cnt - m15_base !== Q_EXP) begin
      nerr++;
      $display("FAIL rollover_min15: got %0d pulses expected %0d", m15_cnt - m15_base, Q_EXP);
    end
    nvec++;
    if (min15 !== 1'b0) begin
      nerr++;
      $display("FAIL rollover_min15_low: got %b expected 0", min15);
    end
  endtask

  task automatic test_quarter_hour();
    logic [25:0] exp_t;
    do_reset();
    set_edit(1'b1);
    pulse(1, 14);
    pulse(0, 59);
    set_edit(1'b0);
    m15_base = m15_cnt;
    baud_edges(1199);
    cyc(6);
    exp_t = tv(0, 0, 0, 14, 59);
    nvec++;
    if (now_t !== exp_t) begin
      nerr++;
      $display("FAIL quarter_before: got %h expected %h", now_t, exp_t);
    end
    baud_edges(1);
    cyc(6);
    exp_t = tv(0, 0, 0, 15, 0);
    nvec++;
    if (now_t !== exp_t) begin
      nerr++;
      $display("FAIL quarter_fields: got %h expected %h", now_t, exp_t);
    end
    nvec++;
    if (m15_cnt - m15_base !== Q_EXP) begin
      nerr++;
      $display("FAIL quarter_min15: got %0d pulses expected %0d", m15_cnt - m15_base, Q_EXP);
    end
  endtask

  task automatic test_reset_mid_edit();
    logic [25:0] exp_t;
    do_reset();
    set_edit(1'b1);
    pulse(0, 5);
    pulse(4, 3);
    exp_t = tv(3, 0, 0, 0, 5);
    nvec++;
    if (now_t !== exp_t) begin
      nerr++;
      $display("FAIL mid_edit_preset: got %h expected %h", now_t, exp_t);
    end
    estb[1] = 1'b1;
    rst = 1'b1;
    cyc(3);
    nvec++;
    if (now_t !== 26'd0) begin
      nerr++;
      $display("FAIL mid_edit_reset: got %h expected %h", now_t, 26'd0);
    end
    estb = 5'd0;
    edit = 1'b0;
    rst = 1'b0;
    cyc(8);
    nvec++;
    if (now_t !== 26'd0) begin
      nerr++;
      $display("FAIL after_mid_edit_reset: got %h expected %h", now_t, 26'd0);
    end
  endtask

  initial begin
    #4ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    test_reset();
    test_edit_seconds();
    test_edit_fields();
    test_edit_wrap_hold();
    test_rollover();
    test_quarter_hour();
    test_reset_mid_edit();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/watch_reload.md
# watch_reload

Calendar/time-of-day counter for the system clock domain. Counts seconds, minutes, hours, days and months from a 1200 Hz timebase input and flags every quarter hour. While an edit mode is active, each field can be stepped manually by per-field strobes. Feeds time stamps and the 15-minute trigger to the sampling/report logic alongside the UART transmitter, whose 1200 baud clock serves as the timebase.

## Interface
Parameters:
- TICKS_PER_SEC, 1200, timebase rising edges per second.
- DAYS_PER_MONTH, 30, day count at which the month advances.

Ports:
- MH50  in  1  system clock, 50 MHz; the only clock, all flops on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- baud_clk  in  1  1200 Hz timebase, asynchronous to MH50; sampled as data, never used as a clock.
- edit  in  1  edit-mode enable, level, asynchronous.
- Esec  in  1  seconds step strobe, asynchronous.
- Emin  in  1  minutes step strobe, asynchronous.
- Ehour  in  1  hours step strobe, asynchronous.
- Eday  in  1  days step strobe, asynchronous.
- Emonths  in  1  months step strobe, asynchronous.
- Hsec  out  6  seconds, 0..59.
- Hmin  out  6  minutes, 0..59.
- Hhour  out  5  hours, 0..23.
- Hday  out  5  day of month, 0..DAYS_PER_MONTH-1.
- Hmon  out  4  month, 0..11.
- min15  out  1  one-cycle quarter-hour pulse.

## Operation
- All asynchronous inputs (baud_clk, edit, E*) pass through 2-flop synchronizers, then rising-edge detection (registered previous value).
- Prescaler: 11-bit counter incremented on each detected baud_clk rising edge while edit=0; at TICKS_PER_SEC-1 it wraps to 0 and issues a one-cycle sec_tick.
- Counting on sec_tick: Hsec+1; at 59 wraps to 0 and carries into Hmin; Hmin 59->0 carries to Hhour; Hhour 23->0 carries to Hday; Hday DAYS_PER_MONTH-1->0 carries to Hmon; Hmon 11->0 (year wrap, no further carry). All carries resolve in the same cycle.
- Edit mode (synchronized edit=1): prescaler and counting frozen (prescaler holds value); each detected rising edge of a field strobe increments that field by 1, wrapping at its own limit with NO carry into the next field. Strobes for different fields in the same cycle each apply. Strobes while edit=0 are ignored.
- Leaving edit mode resumes counting from the held prescaler value.
- min15: asserted for exactly one MH50 cycle on the cycle after a sec_tick that makes Hsec=0 with Hmin in {0,15,30,45}. Edit-mode changes never assert min15.

## Timing
- Reset (rst high at a MH50 edge): Hsec, Hmin, Hhour, Hday, Hmon = 0; min15 = 0; prescaler = 0; synchronizer and edge-detect flops = 0. Reset dominates all other activity, including mid-edit.
- baud_clk edge to prescaler update: 3 MH50 cycles (2 sync + edge detect); outputs registered, update 1 cycle after sec_tick.
- Edit strobe rising edge to field update: 3-4 MH50 cycles. Strobe high time must be ≥ 2 MH50 cycles; one increment per rising edge regardless of pulse length.
- edit deassertion takes effect after the 2-flop synchronizer; a strobe edge arriving in the same cycle as synchronized edit falling is ignored.
- Full rollover (59:59 of 23h, day 29, month 11) returns all fields to 0 in one cycle.

## Configuration
- WATCH_RELOAD_MIN15_EN: defined -> min15 generated as above. Undefined -> min15 tied to 0 and its detection logic removed; counting and editing unaffected.

## Test plan
- Reset: rst high 50 cycles -> all time outputs 0, min15 0; 1199 baud edges -> Hsec still 0, 1200th -> Hsec=1.
- Edit seconds: edit=1, two Esec pulses, edit=0 -> Hsec=2; after 1 s of baud_clk -> Hsec=3.
- Edit every field: two pulses each of Emin, Ehour, Eday, Emonths -> 2 each; after 60 s Hmin=3, 3600 s Hhour=3, 86400 s Hday=3, 2592000 s (30 days) Hmon=3.
- Edit wrap: edit=1, 61 Esec pulses from 0 -> Hsec=1, Hmin unchanged 0; baud edges during edit -> no count.
- Rollover: edit to 23:59:59, day 29, month 11, run 1 s -> all fields 0, min15 one-cycle pulse.
- Quarter hour: from 00:14:59, one second -> Hmin=15, Hsec=0, min15 high exactly 1 cycle; with WATCH_RELOAD_MIN15_EN undefined min15 stays 0.
